// File: rtl/shift_reg_sched_pkg.sv
// Shared types and constants for the shift-register scheduler.
package shift_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int unsigned SHW  = 4;
    localparam int unsigned MDW  = 3;
    localparam int unsigned RPTW = 4;

    localparam logic [SHW-1:0] NOP_SHIFT    = 4'd0;
    localparam logic [MDW-1:0] NOP_MODE_DEF = 3'd0;

endpackage

// File: rtl/shift_reg_sched_rr_arbiter.sv
// Requester arbiter: one-hot grant plus encoded id.
// SHIFT_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins, no pointer port).
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
    input  logic [IDW-1:0]  ptr_i,
`endif
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  id_o,
    output logic            valid_o
);

    logic [IDW-1:0] base;
    logic [IDW-1:0] idx;

`ifdef SHIFT_SCHED_FIXED_PRIO_EN
    assign base = '0;
`else
    assign base = ptr_i;
`endif

    // Scan requesters starting at base, wrapping, and grant the first valid one.
    always_comb begin
        gnt_o   = '0;
        id_o    = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(base) + k) % NREQ);
            if (en_i && !valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                id_o       = idx;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_reg_sched.sv
// Arbitrates NREQ requesters onto one shared universal shift register and
// returns the post-command register value to the owner.
// SHIFT_SCHED_FIXED_PRIO_EN: fixed priority instead of round robin.
module shift_reg_sched
    import shift_sched_pkg::*;
#(
    parameter int unsigned     NREQ     = 4,
    parameter int unsigned     IDW      = 2,
    parameter int unsigned     DW       = 16,
    parameter logic [MDW-1:0]  NOP_MODE = NOP_MODE_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_load,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ*SHW-1:0]  req_shift,
    input  logic [NREQ*MDW-1:0]  req_mode,
    input  logic [NREQ*RPTW-1:0] req_rpt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy,
    output logic                 sr_load,
    output logic [DW-1:0]        sr_data_in,
    output logic [SHW-1:0]       sr_shift,
    output logic [MDW-1:0]       sr_mode,
    input  logic [DW-1:0]        sr_data_out
);

    state_e            state_q, state_d;
    logic [RPTW-1:0]   cnt_q, cnt_d;
    logic              cmd_load_q;
    logic [DW-1:0]     cmd_data_q;
    logic [SHW-1:0]    cmd_shift_q;
    logic [MDW-1:0]    cmd_mode_q;
    logic [IDW-1:0]    gid_q;
    logic [DW-1:0]     rsp_data_q;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic              gnt_valid;
    logic              arb_en;

    logic              sel_load;
    logic [DW-1:0]     sel_data;
    logic [SHW-1:0]    sel_shift;
    logic [MDW-1:0]    sel_mode;
    logic [RPTW-1:0]   sel_rpt;

    // Grants only in IDLE; held off during reset so no requester sees a spurious accept.
    assign arb_en = (state_q == IDLE) && rstn;

`ifndef SHIFT_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    // Pointer moves to one past the granted requester.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) ptr_d = IDW'((32'(gnt_id) + 32'd1) % NREQ);
    end
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (req_valid),
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
        .ptr_i   (ptr_q),
`endif
        .en_i    (arb_en),
        .gnt_o   (gnt),
        .id_o    (gnt_id),
        .valid_o (gnt_valid)
    );

    assign req_ready = gnt;

    // Select the granted requester's command fields.
    always_comb begin
        sel_load  = 1'b0;
        sel_data  = '0;
        sel_shift = '0;
        sel_mode  = '0;
        sel_rpt   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_load  = req_load[i];
                sel_data  = req_data[i*DW +: DW];
                sel_shift = req_shift[i*SHW +: SHW];
                sel_mode  = req_mode[i*MDW +: MDW];
                sel_rpt   = req_rpt[i*RPTW +: RPTW];
            end
        end
    end

    // FSM state and repeat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, step ISSUE rpt+1 times, hold WAIT until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = ISSUE;
                    cnt_d   = sel_rpt;
                end
            end
            ISSUE: begin
                if (cmd_load_q || (cnt_q == '0)) state_d = WAIT;
                else                            cnt_d   = cnt_q - 1'b1;
            end
            WAIT: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture on grant; response data mirror while waiting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_load_q  <= 1'b0;
            cmd_data_q  <= '0;
            cmd_shift_q <= '0;
            cmd_mode_q  <= NOP_MODE;
            gid_q       <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (state_q == IDLE && gnt_valid) begin
                cmd_load_q  <= sel_load;
                cmd_data_q  <= sel_data;
                cmd_shift_q <= sel_shift;
                cmd_mode_q  <= sel_mode;
                gid_q       <= gnt_id;
            end
            if (state_q == WAIT) rsp_data_q <= sr_data_out;
        end
    end

    // Shift-register pins: command in ISSUE, hold pattern on every other cycle.
    always_comb begin
        sr_load    = 1'b0;
        sr_data_in = '0;
        sr_shift   = NOP_SHIFT;
        sr_mode    = NOP_MODE;
        if (state_q == ISSUE) begin
            sr_load    = cmd_load_q;
            sr_data_in = cmd_load_q ? cmd_data_q : '0;
            sr_shift   = cmd_shift_q;
            sr_mode    = cmd_mode_q;
        end
    end

    // The register's own output flop already holds the final value on WAIT entry and the
    // hold pattern keeps it there, so WAIT forwards it directly; the mirror keeps rsp_data
    // stable once the response has been taken.
    assign rsp_valid = (state_q == WAIT);
    assign rsp_id    = gid_q;
    assign rsp_data  = (state_q == WAIT) ? sr_data_out : rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_reg_sched.sv
// Directed bench for shift_reg_sched with a behavioural shift register attached.
// Register modes used here: 0 hold, 1 logical left, 2 logical right.
module tb_shift_reg_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req_valid, req_ready, req_load;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*4-1:0] req_shift, req_rpt;
    logic [NREQ*3-1:0] req_mode;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              busy, sr_load;
    logic [DW-1:0]     sr_data_in, sr_data_out;
    logic [3:0]        sr_shift;
    logic [2:0]        sr_mode;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    shift_reg_sched #(
        .NREQ     (NREQ),
        .IDW      (IDW),
        .DW       (DW),
        .NOP_MODE (3'd0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_load    (req_load),
        .req_data    (req_data),
        .req_shift   (req_shift),
        .req_mode    (req_mode),
        .req_rpt     (req_rpt),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .sr_load     (sr_load),
        .sr_data_in  (sr_data_in),
        .sr_shift    (sr_shift),
        .sr_mode     (sr_mode),
        .sr_data_out (sr_data_out)
    );

    // Behavioural universal shift register with a registered output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        sr_data_out <= '0;
        else if (sr_load) sr_data_out <= sr_data_in;
        else begin
            case (sr_mode)
                3'd1:    sr_data_out <= sr_data_out << sr_shift;
                3'd2:    sr_data_out <= sr_data_out >> sr_shift;
                default: sr_data_out <= sr_data_out;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic ld, input logic [15:0] d,
                           input logic [3:0] sh, input logic [2:0] md, input logic [3:0] rp);
        req_load[id]          = ld;
        req_data[id*DW +: DW] = d;
        req_shift[id*4 +: 4]  = sh;
        req_mode[id*3 +: 3]   = md;
        req_rpt[id*4 +: 4]    = rp;
        req_valid[id]         = 1'b1;
    endtask

    task automatic apply_reset();
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_load  = '0;
        req_data  = '0;
        req_shift = '0;
        req_mode  = '0;
        req_rpt   = '0;
        rsp_ready = 1'b1;
        rstn      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vec_cnt++; if (rsp_id !== 2'd0) begin err_cnt++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        vec_cnt++; if (rsp_data !== 16'h0000) begin err_cnt++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++; if (sr_load !== 1'b0) begin err_cnt++; $display("FAIL reset_sr_load: got %b want 0", sr_load); end
        vec_cnt++; if (sr_data_in !== 16'h0000) begin err_cnt++; $display("FAIL reset_sr_data_in: got %h want 0000", sr_data_in); end
        vec_cnt++; if (sr_shift !== 4'd0) begin err_cnt++; $display("FAIL reset_sr_shift: got %0d want 0", sr_shift); end
        vec_cnt++; if (sr_mode !== 3'd0) begin err_cnt++; $display("FAIL reset_sr_mode: got %0d want 0", sr_mode); end
        req_valid = '0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_load();
        tick();
        set_req(1, 1'b1, 16'hA5C3, 4'd0, 3'd0, 4'd0);
        @(negedge clk);
        vec_cnt++; if (req_ready !== 4'b0010) begin err_cnt++; $display("FAIL load_ready_T: got %b want 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        vec_cnt++; if (sr_load !== 1'b1) begin err_cnt++; $display("FAIL load_sr_load_T1: got %b want 1", sr_load); end
        vec_cnt++; if (sr_data_in !== 16'hA5C3) begin err_cnt++; $display("FAIL load_sr_data_in_T1: got %h want a5c3", sr_data_in); end
        vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL load_ready_T1: got %b want 0000", req_ready); end
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL load_rsp_valid_T1: got %b want 0", rsp_valid); end
        tick();
        @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL load_rsp_valid_T2: got %b want 1", rsp_valid); end
        vec_cnt++; if (rsp_id !== 2'd1) begin err_cnt++; $display("FAIL load_rsp_id: got %0d want 1", rsp_id); end
        vec_cnt++; if (rsp_data !== 16'hA5C3) begin err_cnt++; $display("FAIL load_rsp_data: got %h want a5c3", rsp_data); end
        vec_cnt++; if (sr_load !== 1'b0) begin err_cnt++; $display("FAIL load_sr_load_T2: got %b want 0", sr_load); end
        tick();
        @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL load_rsp_valid_T3: got %b want 0", rsp_valid); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL load_busy_T3: got %b want 0", busy); end
    endtask

    task automatic test_shift();
        int n;
        int issues;
        tick();
        set_req(0, 1'b1, 16'h0001, 4'd0, 3'd0, 4'd0);
        tick();
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        vec_cnt++; if (rsp_data !== 16'h0001) begin err_cnt++; $display("FAIL shift_preload: got %h want 0001", rsp_data); end
        tick();
        set_req(0, 1'b0, 16'h0000, 4'd1, 3'd1, 4'd3);
        tick();
        req_valid[0] = 1'b0;
        issues = 0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            if (sr_shift == 4'd1 && sr_mode == 3'd1 && !sr_load) issues++;
            tick();
            n++;
        end
        vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL shift_rsp_timeout: got %b want 1", rsp_valid); end
        vec_cnt++; if (issues !== 4) begin err_cnt++; $display("FAIL shift_issue_cycles: got %0d want 4", issues); end
        vec_cnt++; if (rsp_data !== 16'h0010) begin err_cnt++; $display("FAIL shift_rsp_data: got %h want 0010", rsp_data); end
        vec_cnt++; if (rsp_id !== 2'd0) begin err_cnt++; $display("FAIL shift_rsp_id: got %0d want 0", rsp_id); end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_g[5];
        int ng;
        int g;
        int last_g;
        int cyc;
        int n;
`ifdef SHIFT_SCHED_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'h1000 + 16'(i), 4'd0, 3'd0, 4'd0);
        ng = 0;
        cyc = 0;
        last_g = 0;
        while (ng < 5 && cyc < 100) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                vec_cnt++; if (!$onehot(req_ready)) begin err_cnt++; $display("FAIL rr_onehot: got %b want one-hot", req_ready); end
                vec_cnt++; if (g !== exp_g[ng]) begin err_cnt++; $display("FAIL rr_grant%0d: got %0d want %0d", ng, g, exp_g[ng]); end
                last_g = g;
                ng++;
            end
            if (rsp_valid) begin
                vec_cnt++; if (32'(rsp_id) !== last_g) begin err_cnt++; $display("FAIL rr_rsp_id: got %0d want %0d", rsp_id, last_g); end
                vec_cnt++; if (rsp_data !== 16'h1000 + 16'(last_g)) begin err_cnt++; $display("FAIL rr_rsp_data: got %h want %h", rsp_data, 16'h1000 + 16'(last_g)); end
            end
            tick();
            cyc++;
        end
        vec_cnt++; if (ng !== 5) begin err_cnt++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
        req_valid = '0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rr_drain: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int n;
        tick();
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 16'h5A5A, 4'd0, 3'd0, 4'd0);
        tick();
        req_valid[2] = 1'b0;
        set_req(3, 1'b1, 16'hFFFF, 4'd0, 3'd0, 4'd0);
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_rsp_timeout: got %b want 1", rsp_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vec_cnt++; if (rsp_data !== 16'h5A5A) begin err_cnt++; $display("FAIL bp_rsp_data c%0d: got %h want 5a5a", c, rsp_data); end
            vec_cnt++; if (sr_data_out !== 16'h5A5A) begin err_cnt++; $display("FAIL bp_sr_data_out c%0d: got %h want 5a5a", c, sr_data_out); end
            vec_cnt++; if (sr_shift !== 4'd0) begin err_cnt++; $display("FAIL bp_sr_shift c%0d: got %0d want 0", c, sr_shift); end
            vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_req_ready c%0d: got %b want 0000", c, req_ready); end
            vec_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin err_cnt++; $display("FAIL bp_rsp_hold c%0d: got valid=%b id=%0d want valid=1 id=2", c, rsp_valid, rsp_id); end
            tick();
        end
        req_valid[3] = 1'b0;
        rsp_ready    = 1'b1;
        tick();
        vec_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_rpt15();
        tick();
        set_req(3, 1'b1, 16'hBEEF, 4'd0, 3'd0, 4'hF);
        @(negedge clk);
        vec_cnt++; if (req_ready !== 4'b1000) begin err_cnt++; $display("FAIL rpt15_ready: got %b want 1000", req_ready); end
        tick();
        req_valid[3] = 1'b0;
        @(negedge clk);
        vec_cnt++; if (sr_load !== 1'b1 || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rpt15_T1: got load=%b valid=%b want 1 0", sr_load, rsp_valid); end
        tick();
        @(negedge clk);
        vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL rpt15_rsp_valid_T2: got %b want 1", rsp_valid); end
        vec_cnt++; if (rsp_data !== 16'hBEEF || rsp_id !== 2'd3) begin err_cnt++; $display("FAIL rpt15_rsp: got %h/%0d want beef/3", rsp_data, rsp_id); end
        tick();
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rpt15_busy_T3: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        tick();
        set_req(1, 1'b0, 16'h0000, 4'd1, 3'd1, 4'd9);
        tick();
        req_valid[1] = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b1 || sr_shift !== 4'd1) begin err_cnt++; $display("FAIL rmid_in_issue: got busy=%b shift=%0d want 1 1", busy, sr_shift); end
        #2 rstn = 1'b0;
        #1;
        vec_cnt++; if (sr_shift !== 4'd0 || sr_mode !== 3'd0 || sr_load !== 1'b0) begin err_cnt++; $display("FAIL rmid_hold: got load=%b shift=%0d mode=%0d want 0 0 0", sr_load, sr_shift, sr_mode); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy: got %b want 0", busy); end
        seen = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL rmid_no_rsp: got %b want 0", seen); end
        tick();
        set_req(2, 1'b1, 16'h1234, 4'd0, 3'd0, 4'd0);
        tick();
        req_valid[2] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'h1234) begin err_cnt++; $display("FAIL rmid_next_cmd: got v=%b id=%0d d=%h want 1 2 1234", rsp_valid, rsp_id, rsp_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift();
        test_round_robin();
        test_backpressure();
        test_rpt15();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
